fifo_ratio_unpack: RTL and testbench

//  Parametrised wide-to-narrow FIFO; successor to the fixed 16:1 unpacker.
//  - Buffers up to 2**ABITS wide words of RATIO sub-words each.
//  - Emits sub-words one per handshake on an AXI-S-style output; last_o marks the final sub-word of each entry.
//  - New over the fixed block:
//    - run-time per-entry sub-word count, allowing short final words of a USB packet;
//    - selectable sub-word order;
//    - fill-level output.
//  - Sits between the wide packet/endpoint buffers and narrow USB datapaths.

---
 rtl/usb_fifo_pkg.sv | 14 +
 rtl/sync_fifo_fwft.sv | 74 +++++++
 rtl/fifo_ratio_unpack.sv | 105 ++++++++++
 tb/tb_fifo_ratio_unpack.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_fifo_pkg.sv
// Shared width helpers for the USB FIFO family.
//   cnt_bits(ratio) : width of the per-entry sub-word count field
//   ptr_bits(abits) : width of a FIFO pointer (one extra bit to tell full from empty)
package usb_fifo_pkg;

    function automatic int unsigned cnt_bits(input int unsigned ratio);
        return (ratio < 2) ? 1 : $clog2(ratio);
    endfunction

    function automatic int unsigned ptr_bits(input int unsigned abits);
        return abits + 1;
    endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// Generic first-word-fall-through register FIFO with fill level.
// Ports:
//   clock, reset          rising-edge clock, synchronous active-high reset
//   wr_valid_i/wr_ready_o write handshake; wr_ready_o depends on registered state only
//   wr_data_i             write data
//   rd_valid_o            head entry present
//   rd_data_o             head entry (valid the cycle after it is written)
//   rd_pop_i              discard head entry (ignored while empty)
//   level_o               occupied entries, 0..2**ABITS
module sync_fifo_fwft
    import usb_fifo_pkg::*;
#(
    parameter int unsigned DW    = 8,
    parameter int unsigned ABITS = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             wr_valid_i,
    output logic             wr_ready_o,
    input  logic [DW-1:0]    wr_data_i,
    output logic             rd_valid_o,
    output logic [DW-1:0]    rd_data_o,
    input  logic             rd_pop_i,
    output logic [ABITS:0]   level_o
);

    localparam int unsigned DEPTH = 2 ** ABITS;
    localparam int unsigned PW    = ptr_bits(ABITS);

    logic [DW-1:0] mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic          wr_en;
    logic          rd_en;

    // Pointers wrap modulo 2*DEPTH, so the difference is the exact fill level
    // and its top bit is set only when completely full.
    assign level_o    = wr_ptr_q - rd_ptr_q;
    assign wr_ready_o = !reset && !level_o[ABITS];
    assign rd_valid_o = (level_o != '0);
    assign rd_data_o  = mem_q[rd_ptr_q[ABITS-1:0]];

    assign wr_en = wr_valid_i && wr_ready_o;
    assign rd_en = rd_pop_i && rd_valid_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: contents are only visible while level_o != 0.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem_q[wr_ptr_q[ABITS-1:0]] <= wr_data_i;
        end
    end

endmodule

// File: rtl/fifo_ratio_unpack.sv
// Wide-to-narrow FIFO: buffers wide words of RATIO sub-words and emits them
// one sub-word per handshake, with a per-entry run-time sub-word count.
// Ports:
//   clock, reset   rising-edge clock, synchronous active-high reset
//   valid_i        write request
//   ready_o        FIFO can accept a wide word (registered state only)
//   data_i         wide input word, WIDTH*RATIO bits
//   count_i        valid sub-words minus 1; clamped to RATIO-1 on write
//   valid_o        sub-word available
//   ready_i        consumer accepts sub-word
//   last_o         current sub-word is the final one of its entry
//   data_o         current sub-word
//   level_o        occupied wide entries, 0..2**ABITS
module fifo_ratio_unpack
    import usb_fifo_pkg::*;
#(
    parameter int unsigned WIDTH     = 2,
    parameter int unsigned RATIO     = 16,
    parameter int unsigned ABITS     = 2,
    parameter bit          MSB_FIRST = 1'b0,
    localparam int unsigned CBITS    = cnt_bits(RATIO)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   valid_i,
    output logic                   ready_o,
    input  logic [WIDTH*RATIO-1:0] data_i,
    input  logic [CBITS-1:0]       count_i,
    output logic                   valid_o,
    input  logic                   ready_i,
    output logic                   last_o,
    output logic [WIDTH-1:0]       data_o,
    output logic [ABITS:0]         level_o
);

    localparam int unsigned           DBITS   = WIDTH * RATIO;
    localparam int unsigned           EW      = CBITS + DBITS;
    localparam logic [CBITS-1:0]      CNT_MAX = CBITS'(RATIO - 1);

    logic [CBITS-1:0] count_clamped;
    logic [EW-1:0]    wr_entry;
    logic [EW-1:0]    rd_entry;
    logic             fifo_valid;
    logic             pop_entry;
    logic             beat;
    logic [CBITS-1:0] rd_count;
    logic [DBITS-1:0] rd_word;
    logic [CBITS-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] slice [RATIO];

    // Clamping only bites when RATIO is not a power of two.
    assign count_clamped = (count_i > CNT_MAX) ? CNT_MAX : count_i;
    assign wr_entry      = {count_clamped, data_i};

    sync_fifo_fwft #(
        .DW    (EW),
        .ABITS (ABITS)
    ) u_fifo (
        .clock      (clock),
        .reset      (reset),
        .wr_valid_i (valid_i),
        .wr_ready_o (ready_o),
        .wr_data_i  (wr_entry),
        .rd_valid_o (fifo_valid),
        .rd_data_o  (rd_entry),
        .rd_pop_i   (pop_entry),
        .level_o    (level_o)
    );

    assign rd_count = rd_entry[EW-1 -: CBITS];
    assign rd_word  = rd_entry[DBITS-1:0];

    // Slice table reordered once so the emit mux is a plain index by idx.
    always_comb begin
        for (int unsigned i = 0; i < RATIO; i++) begin
            if (MSB_FIRST) begin
                slice[i] = rd_word[(RATIO-1-i)*WIDTH +: WIDTH];
            end else begin
                slice[i] = rd_word[i*WIDTH +: WIDTH];
            end
        end
    end

    assign valid_o   = fifo_valid;
    assign last_o    = fifo_valid && (idx_q == rd_count);
    assign data_o    = slice[idx_q];
    assign beat      = fifo_valid && ready_i;
    assign pop_entry = beat && last_o;

    always_comb begin
        idx_d = idx_q;
        if (beat) begin
            idx_d = last_o ? '0 : idx_q + CBITS'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            idx_q <= '0;
        end else begin
            idx_q <= idx_d;
        end
    end

endmodule

// File: tb/tb_fifo_ratio_unpack.sv
module tb_fifo_ratio_unpack;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // dut0: WIDTH=2 RATIO=16 ABITS=2 LSB-first
    logic        v_i0, r_o0, v_o0, r_i0, l_o0;
    logic [31:0] d_i0;
    logic [3:0]  c_i0;
    logic [1:0]  d_o0;
    logic [2:0]  lv0;
    // dut1: MSB-first
    logic        v_i1, r_o1, v_o1, r_i1, l_o1;
    logic [31:0] d_i1;
    logic [3:0]  c_i1;
    logic [1:0]  d_o1;
    logic [2:0]  lv1;
    // dut2: RATIO=3 (non power of two), ABITS=1
    logic        v_i2, r_o2, v_o2, r_i2, l_o2;
    logic [5:0]  d_i2;
    logic [1:0]  c_i2;
    logic [1:0]  d_o2;
    logic [1:0]  lv2;

    fifo_ratio_unpack #(.WIDTH(2), .RATIO(16), .ABITS(2), .MSB_FIRST(1'b0)) dut0 (
        .clock(clock), .reset(reset), .valid_i(v_i0), .ready_o(r_o0), .data_i(d_i0),
        .count_i(c_i0), .valid_o(v_o0), .ready_i(r_i0), .last_o(l_o0), .data_o(d_o0),
        .level_o(lv0));

    fifo_ratio_unpack #(.WIDTH(2), .RATIO(16), .ABITS(2), .MSB_FIRST(1'b1)) dut1 (
        .clock(clock), .reset(reset), .valid_i(v_i1), .ready_o(r_o1), .data_i(d_i1),
        .count_i(c_i1), .valid_o(v_o1), .ready_i(r_i1), .last_o(l_o1), .data_o(d_o1),
        .level_o(lv1));

    fifo_ratio_unpack #(.WIDTH(2), .RATIO(3), .ABITS(1), .MSB_FIRST(1'b0)) dut2 (
        .clock(clock), .reset(reset), .valid_i(v_i2), .ready_o(r_o2), .data_i(d_i2),
        .count_i(c_i2), .valid_o(v_o2), .ready_i(r_i2), .last_o(l_o2), .data_o(d_o2),
        .level_o(lv2));

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clock);
        checks++;
        if ({r_o0, r_o1, r_o2} !== 3'b000) begin
            errors++;
            $display("FAIL reset_ready got %b want 000", {r_o0, r_o1, r_o2});
        end
        checks++;
        if ({v_o0, l_o0, lv0, v_o1, l_o1, lv1, v_o2, l_o2, lv2} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got v/l/lv %b %b %0d %b %b %0d %b %b %0d want all 0",
                     v_o0, l_o0, lv0, v_o1, l_o1, lv1, v_o2, l_o2, lv2);
        end
        reset = 1'b0;
        @(negedge clock);
        checks++;
        if ({r_o0, r_o1, r_o2} !== 3'b111 || {v_o0, lv0} !== 4'd0) begin
            errors++;
            $display("FAIL post_reset got ready=%b valid0=%b level0=%0d want 111 0 0",
                     {r_o0, r_o1, r_o2}, v_o0, lv0);
        end
    endtask

    task automatic test_stream();
        logic [31:0] w [5];
        for (int i = 0; i < 5; i++) w[i] = $urandom();
        r_i0 = 1'b1;
        fork
            begin
                for (int i = 0; i < 5; i++) begin
                    int unsigned t;
                    logic acc;
                    v_i0 = 1'b1; d_i0 = w[i]; c_i0 = 4'd15; t = 0;
                    do begin
                        acc = r_o0;
                        @(negedge clock);
                        t++;
                    end while (!acc && t < 40);
                    if (!acc) begin
                        checks++; errors++;
                        $display("FAIL stream_write_timeout word %0d", i);
                    end
                end
                v_i0 = 1'b0;
            end
            begin
                for (int k = 0; k < 80; k++) begin
                    int unsigned t;
                    logic [31:0] cw;
                    logic [1:0]  ed;
                    logic        el;
                    t = 0;
                    while (v_o0 !== 1'b1 && t < 40) begin
                        @(negedge clock);
                        t++;
                    end
                    cw = w[k/16];
                    ed = cw[(k%16)*2 +: 2];
                    el = ((k % 16) == 15);
                    checks++;
                    if (v_o0 !== 1'b1 || d_o0 !== ed || l_o0 !== el) begin
                        errors++;
                        $display("FAIL stream_sub k=%0d got v=%b d=%0d l=%b want v=1 d=%0d l=%b",
                                 k, v_o0, d_o0, l_o0, ed, el);
                    end
                    @(negedge clock);
                end
            end
        join
        checks++;
        if (lv0 !== 3'd0 || v_o0 !== 1'b0) begin
            errors++;
            $display("FAIL stream_end got level=%0d valid=%b want 0 0", lv0, v_o0);
        end
    endtask

    task automatic test_full();
        logic [31:0] w [4];
        r_i0 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            w[i] = $urandom();
            checks++;
            if (r_o0 !== 1'b1) begin
                errors++;
                $display("FAIL full_ready_before_write%0d got %b want 1", i, r_o0);
            end
            v_i0 = 1'b1; d_i0 = w[i]; c_i0 = 4'd15;
            @(negedge clock);
            checks++;
            if (lv0 !== 3'(i + 1)) begin
                errors++;
                $display("FAIL full_level%0d got %0d want %0d", i, lv0, i + 1);
            end
        end
        d_i0 = 32'hDEAD_BEEF;
        repeat (3) @(negedge clock);
        v_i0 = 1'b0;
        checks++;
        if (r_o0 !== 1'b0 || lv0 !== 3'd4 || d_o0 !== w[0][1:0] || l_o0 !== 1'b0) begin
            errors++;
            $display("FAIL full_hold got ready=%b level=%0d d=%0d l=%b want 0 4 %0d 0",
                     r_o0, lv0, d_o0, l_o0, w[0][1:0]);
        end
        r_i0 = 1'b1;
        for (int k = 0; k < 64; k++) begin
            logic [31:0] cw;
            logic [1:0]  ed;
            logic        el;
            cw = w[k/16];
            ed = cw[(k%16)*2 +: 2];
            el = ((k % 16) == 15);
            checks++;
            if (v_o0 !== 1'b1 || d_o0 !== ed || l_o0 !== el) begin
                errors++;
                $display("FAIL full_drain k=%0d got v=%b d=%0d l=%b want v=1 d=%0d l=%b",
                         k, v_o0, d_o0, l_o0, ed, el);
            end
            if (k == 15) begin
                checks++;
                if (r_o0 !== 1'b0) begin
                    errors++;
                    $display("FAIL full_no_passthrough got ready=%b want 0", r_o0);
                end
            end
            @(negedge clock);
        end
        checks++;
        if (lv0 !== 3'd0 || v_o0 !== 1'b0) begin
            errors++;
            $display("FAIL full_end got level=%0d valid=%b want 0 0", lv0, v_o0);
        end
    endtask

    task automatic test_count();
        logic [31:0] w [3];
        logic [3:0]  cn [3];
        logic [1:0]  ed2 [5];
        logic        el2 [5];
        cn[0] = 4'd0; cn[1] = 4'd2; cn[2] = 4'd15;
        r_i0 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            w[i] = $urandom();
            v_i0 = 1'b1; d_i0 = w[i]; c_i0 = cn[i];
            @(negedge clock);
        end
        v_i0 = 1'b0;
        r_i0 = 1'b1;
        for (int e = 0; e < 3; e++) begin
            for (int j = 0; j <= int'(cn[e]); j++) begin
                logic [31:0] cw;
                logic [1:0]  ed;
                logic        el;
                cw = w[e];
                ed = cw[j*2 +: 2];
                el = (j == int'(cn[e]));
                checks++;
                if (v_o0 !== 1'b1 || d_o0 !== ed || l_o0 !== el) begin
                    errors++;
                    $display("FAIL count_e%0d_j%0d got v=%b d=%0d l=%b want v=1 d=%0d l=%b",
                             e, j, v_o0, d_o0, l_o0, ed, el);
                end
                @(negedge clock);
            end
        end
        checks++;
        if (lv0 !== 3'd0 || v_o0 !== 1'b0) begin
            errors++;
            $display("FAIL count_end got level=%0d valid=%b want 0 0", lv0, v_o0);
        end
        // RATIO=3: count 3 clamps to 2 (three sub-words); count 1 gives two.
        ed2 = '{2'd3, 2'd1, 2'd2, 2'd1, 2'd3};
        el2 = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        r_i2 = 1'b0;
        v_i2 = 1'b1; d_i2 = 6'b10_01_11; c_i2 = 2'd3;
        @(negedge clock);
        d_i2 = 6'b00_11_01; c_i2 = 2'd1;
        @(negedge clock);
        v_i2 = 1'b0;
        checks++;
        if (lv2 !== 2'd2 || r_o2 !== 1'b0) begin
            errors++;
            $display("FAIL clamp_full got level=%0d ready=%b want 2 0", lv2, r_o2);
        end
        r_i2 = 1'b1;
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (v_o2 !== 1'b1 || d_o2 !== ed2[k] || l_o2 !== el2[k]) begin
                errors++;
                $display("FAIL clamp_sub k=%0d got v=%b d=%0d l=%b want v=1 d=%0d l=%b",
                         k, v_o2, d_o2, l_o2, ed2[k], el2[k]);
            end
            @(negedge clock);
        end
        checks++;
        if (lv2 !== 2'd0 || v_o2 !== 1'b0) begin
            errors++;
            $display("FAIL clamp_end got level=%0d valid=%b want 0 0", lv2, v_o2);
        end
    endtask

    task automatic test_msb_first();
        r_i1 = 1'b0;
        v_i1 = 1'b1; d_i1 = 32'hE4E4_E4E4; c_i1 = 4'd15;
        @(negedge clock);
        d_i1 = 32'h9000_0000; c_i1 = 4'd1;
        @(negedge clock);
        v_i1 = 1'b0;
        r_i1 = 1'b1;
        for (int k = 0; k < 18; k++) begin
            logic [1:0] ed;
            logic       el;
            if (k < 16) begin
                ed = 2'(3 - (k % 4));
                el = (k == 15);
            end else begin
                ed = (k == 16) ? 2'd2 : 2'd1;
                el = (k == 17);
            end
            checks++;
            if (v_o1 !== 1'b1 || d_o1 !== ed || l_o1 !== el) begin
                errors++;
                $display("FAIL msb_sub k=%0d got v=%b d=%0d l=%b want v=1 d=%0d l=%b",
                         k, v_o1, d_o1, l_o1, ed, el);
            end
            @(negedge clock);
        end
        checks++;
        if (lv1 !== 3'd0 || v_o1 !== 1'b0) begin
            errors++;
            $display("FAIL msb_end got level=%0d valid=%b want 0 0", lv1, v_o1);
        end
    endtask

    task automatic test_stall_overlap(output logic [31:0] b_word);
        logic [31:0] a, b, c;
        a = $urandom(); b = $urandom(); c = $urandom();
        b_word = b;
        r_i0 = 1'b0;
        v_i0 = 1'b1; d_i0 = a; c_i0 = 4'd15;
        @(negedge clock);
        d_i0 = b;
        @(negedge clock);
        v_i0 = 1'b0;
        r_i0 = 1'b1;
        for (int k = 0; k < 16; k++) begin
            logic [1:0] ed;
            ed = a[k*2 +: 2];
            checks++;
            if (v_o0 !== 1'b1 || d_o0 !== ed || l_o0 !== (k == 15)) begin
                errors++;
                $display("FAIL stall_sub k=%0d got v=%b d=%0d l=%b want v=1 d=%0d l=%b",
                         k, v_o0, d_o0, l_o0, ed, (k == 15));
            end
            if (k == 15) begin
                checks++;
                if (lv0 !== 3'd2 || r_o0 !== 1'b1) begin
                    errors++;
                    $display("FAIL overlap_pre got level=%0d ready=%b want 2 1", lv0, r_o0);
                end
                v_i0 = 1'b1; d_i0 = c; c_i0 = 4'd15;
                @(negedge clock);
                v_i0 = 1'b0;
                checks++;
                if (lv0 !== 3'd2 || d_o0 !== b[1:0] || l_o0 !== 1'b0) begin
                    errors++;
                    $display("FAIL overlap_post got level=%0d d=%0d l=%b want 2 %0d 0",
                             lv0, d_o0, l_o0, b[1:0]);
                end
            end else if ($urandom_range(0, 1) == 1) begin
                r_i0 = 1'b0;
                repeat ($urandom_range(1, 3)) @(negedge clock);
                checks++;
                if (v_o0 !== 1'b1 || d_o0 !== ed || l_o0 !== 1'b0) begin
                    errors++;
                    $display("FAIL stall_hold k=%0d got v=%b d=%0d l=%b want v=1 d=%0d l=0",
                             k, v_o0, d_o0, l_o0, ed);
                end
                r_i0 = 1'b1;
                @(negedge clock);
            end else begin
                @(negedge clock);
            end
        end
        r_i0 = 1'b0;
    endtask

    task automatic test_reset_mid(input logic [31:0] b);
        logic [31:0] dw;
        dw = $urandom();
        r_i0 = 1'b1;
        repeat (7) @(negedge clock);
        r_i0 = 1'b0;
        checks++;
        if (d_o0 !== b[14 +: 2] || lv0 !== 3'd2 || l_o0 !== 1'b0) begin
            errors++;
            $display("FAIL mid_idx7 got d=%0d level=%0d l=%b want %0d 2 0",
                     d_o0, lv0, l_o0, b[14 +: 2]);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (r_o0 !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_ready got %b want 0", r_o0);
        end
        @(negedge clock);
        reset = 1'b0;
        checks++;
        if (v_o0 !== 1'b0 || lv0 !== 3'd0 || l_o0 !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_clear got v=%b level=%0d l=%b want 0 0 0", v_o0, lv0, l_o0);
        end
        v_i0 = 1'b1; d_i0 = dw; c_i0 = 4'd15;
        @(negedge clock);
        v_i0 = 1'b0;
        checks++;
        if (v_o0 !== 1'b1 || d_o0 !== dw[1:0] || lv0 !== 3'd1 || l_o0 !== 1'b0) begin
            errors++;
            $display("FAIL mid_post_write got v=%b d=%0d level=%0d l=%b want 1 %0d 1 0",
                     v_o0, d_o0, lv0, l_o0, dw[1:0]);
        end
        r_i0 = 1'b1;
        for (int k = 0; k < 16; k++) begin
            checks++;
            if (v_o0 !== 1'b1 || d_o0 !== dw[k*2 +: 2] || l_o0 !== (k == 15)) begin
                errors++;
                $display("FAIL mid_drain k=%0d got v=%b d=%0d l=%b want v=1 d=%0d l=%b",
                         k, v_o0, d_o0, l_o0, dw[k*2 +: 2], (k == 15));
            end
            @(negedge clock);
        end
        r_i0 = 1'b0;
        checks++;
        if (lv0 !== 3'd0 || v_o0 !== 1'b0) begin
            errors++;
            $display("FAIL mid_end got level=%0d valid=%b want 0 0", lv0, v_o0);
        end
    endtask

    initial begin
        logic [31:0] b_saved;
        reset = 1'b1;
        v_i0 = 1'b0; d_i0 = '0; c_i0 = '0; r_i0 = 1'b0;
        v_i1 = 1'b0; d_i1 = '0; c_i1 = '0; r_i1 = 1'b0;
        v_i2 = 1'b0; d_i2 = '0; c_i2 = '0; r_i2 = 1'b0;
        @(negedge clock);
        test_reset();
        test_stream();
        test_full();
        test_count();
        test_msb_first();
        test_stall_overlap(b_saved);
        test_reset_mid(b_saved);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
